serial_adder: RTL and testbench

//  Bit-serial adder: adds two WIDTH-bit operands LSB-first, one bit per clock, through one full_adder instance.
//  The carry is held in a flip-flop between cycles.

---
 rtl/serial_adder_pkg.sv | 14 +
 rtl/full_adder.sv | 13 +
 rtl/serial_adder.sv | 108 ++++++++++
 tb/tb_serial_adder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   function automatic logic accepts_start(input state_t s);
      return (s == S_IDLE) || (s == S_DONE);
   endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder used for each serial bit step.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic carry
);

   assign sum   = a ^ b ^ cin;
   assign carry = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full adder, LSB-first, one bit per clock behind a start/done handshake.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int            CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_sha;
   logic [WIDTH-1:0] r_shb;
   logic [WIDTH-1:0] r_sum_sh;
   logic [WIDTH-1:0] r_sum;
   logic [CW-1:0]    r_cnt;
   logic             r_carry;
   logic             r_cout;

   logic             w_accept;
   logic             w_run;
   logic             w_last;
   logic             w_s;
   logic             w_co;
   logic [WIDTH-1:0] w_sum_next;

   assign w_accept = start && accepts_start(r_state);
   assign w_run    = (r_state == S_RUN);
   assign w_last   = w_run && (r_cnt == LAST);

   full_adder u_fa (
      .a     (r_sha[0]),
      .b     (r_shb[0]),
      .cin   (r_carry),
      .sum   (w_s),
      .carry (w_co)
   );

   // New bit enters at the MSB; after WIDTH steps the LSB-first bits line up.
   always_comb begin
      w_sum_next            = r_sum_sh >> 1;
      w_sum_next[WIDTH-1]   = w_s;
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = S_IDLE;
      case (r_state)
         S_IDLE:  w_next = start  ? S_RUN  : S_IDLE;
         S_RUN:   w_next = w_last ? S_DONE : S_RUN;
         S_DONE:  w_next = start  ? S_RUN  : S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state == S_RUN);
      done = (r_state == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sha    <= '0;
         r_shb    <= '0;
         r_sum_sh <= '0;
         r_carry  <= 1'b0;
         r_cnt    <= '0;
         r_sum    <= '0;
         r_cout   <= 1'b0;
      end else if (w_accept) begin
         r_sha    <= a;
         r_shb    <= b;
         r_carry  <= cin;
         r_cnt    <= '0;
         r_sum_sh <= '0;
      end else if (w_run) begin
         r_sha    <= r_sha >> 1;
         r_shb    <= r_shb >> 1;
         r_carry  <= w_co;
         r_cnt    <= r_cnt + CW'(1);
         r_sum_sh <= w_sum_next;
         if (w_last) begin
            r_sum  <= w_sum_next;
            r_cout <= w_co;
         end
      end
   end

   assign sum  = r_sum;
   assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=4): directed cases, random traffic, exhaustive sweep.
module tb_serial_adder;

   localparam int WIDTH = 4;

   logic             clk;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   logic [WIDTH:0]   exp_q[$];
   logic [WIDTH:0]   last_res;
   int               n_tests;
   int               n_fail;
   int               busy_run;
   int               done_cnt;

   serial_adder #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: plain integer addition truncated to WIDTH+1 bits.
   function automatic logic [WIDTH:0] ref_add(input int x, input int y, input int c);
      int s;
      s = (x + y + c) % (1 << (WIDTH + 1));
      return s[WIDTH:0];
   endfunction

   // Monitor: pops the scoreboard whenever done is presented.
   always @(negedge clk) begin
      if (rst) begin
         busy_run = 0;
         last_res = '0;
      end else begin
         if (busy && done) check("busy_and_done", 1, 0);
         if (busy) busy_run++;
         if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               last_res = exp_q.pop_front();
               check("result", int'({cout, sum}), int'(last_res));
               check("busy_cycles", busy_run, WIDTH);
            end
            busy_run = 0;
         end else begin
            check("hold", int'({cout, sum}), int'(last_res));
         end
      end
   end

   // Must be called while the DUT is in IDLE or DONE, before the accepting edge.
   task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c);
      a     = x;
      b     = y;
      cin   = c;
      start = 1'b1;
      exp_q.push_back(ref_add(int'(x), int'(y), int'(c)));
      @(posedge clk);
      #1;
      start = 1'b0;
      a     = WIDTH'($urandom);
      b     = WIDTH'($urandom);
      cin   = 1'($urandom);
   endtask

   // Returns at the negedge inside the done cycle.
   task automatic wait_done(input int exp_lat);
      int  cyc;
      bit  seen;
      cyc  = 0;
      seen = 0;
      while (!seen && cyc < WIDTH + 6) begin
         @(negedge clk);
         cyc++;
         if (done) seen = 1;
      end
      if (!seen) check("done_timeout", 0, 1);
      else       check("latency", cyc, exp_lat);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int d0;
      n_tests  = 0;
      n_fail   = 0;
      busy_run = 0;
      done_cnt = 0;
      last_res = '0;
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      cin   = 1'b0;
      idle(3);
      rst = 1'b0;
      @(negedge clk);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      check("reset_sum",  int'(sum),  0);
      check("reset_cout", int'(cout), 0);

      // Basic adds and wrap-around.
      idle(1);
      issue(4'd5, 4'd3, 1'b0);   wait_done(WIDTH + 1);
      idle(2);
      issue(4'd15, 4'd1, 1'b0);  wait_done(WIDTH + 1);
      idle(1);
      issue(4'd15, 4'd15, 1'b1); wait_done(WIDTH + 1);
      idle(2);

      // start held through RUN with other operands: one result only.
      d0 = done_cnt;
      issue(4'd6, 4'd9, 1'b0);
      start = 1'b1;
      a     = 4'd9;
      b     = 4'd7;
      cin   = 1'b1;
      repeat (WIDTH) @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(1);
      idle(WIDTH + 3);
      check("single_done", done_cnt - d0, 1);

      // Reset mid-RUN aborts with no done.
      d0 = done_cnt;
      issue(4'd11, 4'd7, 1'b1);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_busy", int'(busy), 0);
      check("abort_sum",  int'(sum),  0);
      check("abort_cout", int'(cout), 0);
      idle(WIDTH + 4);
      check("abort_no_done", done_cnt - d0, 0);

      // Back-to-back: start in the DONE cycle.
      issue(4'd7, 4'd8, 1'b0);
      wait_done(WIDTH + 1);
      issue(4'd2, 4'd2, 1'b0);
      wait_done(WIDTH + 1);
      idle(1);

      // Random traffic with random gaps.
      for (int i = 0; i < 150; i++) begin
         issue(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
         wait_done(WIDTH + 1);
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      end
      idle(1);

      // Exhaustive sweep, back-to-back.
      for (int x = 0; x < 512; x++) begin
         logic [8:0] v;
         v = 9'(x);
         issue(v[3:0], v[7:4], v[8]);
         wait_done(WIDTH + 1);
      end
      idle(3);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
